// File: rtl/cus19_prog_loader.sv
// cus19_prog_loader: framed byte-stream loader writing imem words and dmem bytes while holding the CPU
module cus19_prog_loader #(
    parameter int PC_Width        = 11,
    parameter int Instr_Width     = 19,
    parameter int Data_Width      = 8,
    parameter int Dmem_Addr_Width = 8,
    parameter logic [7:0] Cmd_Imem = 8'h5A,
    parameter logic [7:0] Cmd_Dmem = 8'hC3
) (
    input  logic                       cus19_clk_in,
    input  logic                       cus19_rst_in,
    input  logic [7:0]                 ld_byte_in,
    input  logic                       ld_valid_in,
    output logic                       ld_ready_out,
    output logic                       imem_we_out,
    output logic [PC_Width-1:0]        imem_addr_out,
    output logic [Instr_Width-1:0]     imem_wdata_out,
    output logic                       dmem_we_out,
    output logic [Dmem_Addr_Width-1:0] dmem_addr_out,
    output logic [Data_Width-1:0]      dmem_wdata_out,
    output logic                       cpu_hold_out,
    output logic                       ld_done_out,
    output logic                       ld_err_out
);
    typedef enum logic [3:0] {
        S_IDLE, S_ADDR_H, S_ADDR_L, S_CNT_H, S_CNT_L,
        S_DATA0, S_DATA1, S_DATA2, S_WRITE, S_DONE
    } state_t;
    state_t state, state_nx;
    logic is_imem;
    logic [PC_Width-1:0] addr;
    logic [15:0] rem;
    logic [Instr_Width-9:0] sh;
    logic acc, cmd_ok;
    assign ld_ready_out = !cus19_rst_in && state != S_WRITE && state != S_DONE;
    assign acc          = ld_valid_in && ld_ready_out;
    assign cmd_ok       = ld_byte_in == Cmd_Imem || ld_byte_in == Cmd_Dmem;
    assign cpu_hold_out = state != S_IDLE && state != S_DONE;
    assign ld_done_out  = state == S_DONE;
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   state_nx = acc && cmd_ok ? S_ADDR_H : S_IDLE;
            S_ADDR_H: state_nx = acc ? S_ADDR_L : state;
            S_ADDR_L: state_nx = acc ? S_CNT_H : state;
            S_CNT_H:  state_nx = acc ? S_CNT_L : state;
            S_CNT_L:  state_nx = !acc ? state : {rem[15:8], ld_byte_in} == 16'd0 ? S_DONE : S_DATA0;
            S_DATA0:  state_nx = !acc ? state : is_imem ? S_DATA1 : S_WRITE;
            S_DATA1:  state_nx = acc ? S_DATA2 : state;
            S_DATA2:  state_nx = acc ? S_WRITE : state;
            S_WRITE:  state_nx = rem == 16'd1 ? S_DONE : S_DATA0;
            default:  state_nx = S_IDLE;
        endcase
    end
    always_ff @(posedge cus19_clk_in) begin
        if (cus19_rst_in) begin
            state          <= S_IDLE;
            is_imem        <= 1'b0;
            addr           <= '0;
            rem            <= '0;
            sh             <= '0;
            imem_we_out    <= 1'b0;
            imem_addr_out  <= '0;
            imem_wdata_out <= '0;
            dmem_we_out    <= 1'b0;
            dmem_addr_out  <= '0;
            dmem_wdata_out <= '0;
            ld_err_out     <= 1'b0;
        end else begin
            state       <= state_nx;
            imem_we_out <= 1'b0;
            dmem_we_out <= 1'b0;
            ld_err_out  <= 1'b0;
            if (acc) begin
                case (state)
                    S_IDLE: begin
                        is_imem    <= ld_byte_in == Cmd_Imem;
                        ld_err_out <= !cmd_ok;
                    end
                    S_ADDR_H: addr[PC_Width-1:8] <= ld_byte_in[PC_Width-9:0];
                    S_ADDR_L: addr[7:0] <= ld_byte_in;
                    S_CNT_H:  rem[15:8] <= ld_byte_in;
                    S_CNT_L:  rem[7:0] <= ld_byte_in;
                    S_DATA0: begin
                        sh <= {sh[Instr_Width-17:0], ld_byte_in};
                        if (!is_imem) begin
                            dmem_we_out    <= 1'b1;
                            dmem_addr_out  <= addr[Dmem_Addr_Width-1:0];
                            dmem_wdata_out <= ld_byte_in;
                        end
                    end
                    S_DATA1:  sh <= {sh[Instr_Width-17:0], ld_byte_in};
                    S_DATA2: begin
                        imem_we_out    <= 1'b1;
                        imem_addr_out  <= addr;
                        imem_wdata_out <= {sh, ld_byte_in};
                    end
                    default: ;
                endcase
            end
            if (state == S_WRITE) begin
                addr <= addr + 1'b1;
                rem  <= rem - 16'd1;
            end
        end
    end
endmodule
